// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
//
// Shared types and sizing constants for the fetch-to-decode instruction queue.
//
//   IQ_DEPTH     default number of queue entries (power of two)
//   IQ_ID_WIDTH  default number of dequeue slots; equals the ID decode width
//   fetch_pkt_t  one fetch packet: PC, instruction word and branch prediction
// -----------------------------------------------------------------------------
package inst_queue_pkg;

   localparam int IQ_DEPTH    = 16;
   localparam int IQ_ID_WIDTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
      logic [31:0] pred_target;
   } fetch_pkt_t;

endpackage : inst_queue_pkg

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Decoupling buffer between fetch and the ID stage. Fetch enqueues at most one
// packet per cycle; ID sees the ID_WIDTH oldest packets every cycle and, with
// deq_ready, consumes all of the presented ones at once. A backend flush empties
// the queue at the next edge.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; clears the pointers only
//   flush      discard all entries; overrides enqueue and dequeue this cycle
//   enq_valid  fetch presents enq_pkt
//   enq_ready  queue has a free entry (registered state only)
//   enq_pkt    packet offered by fetch
//   deq_valid  thermometer-coded slot valids, slot 0 = oldest entry
//   deq_pkt    packet per slot; don't-care where deq_valid[i] = 0
//   deq_ready  ID consumes every valid slot this cycle
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH    = IQ_DEPTH,
   parameter int ID_WIDTH = IQ_ID_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      enq_valid,
   output logic                      enq_ready,
   input  fetch_pkt_t                enq_pkt,
   output logic [ID_WIDTH-1:0]       deq_valid,
   output fetch_pkt_t [ID_WIDTH-1:0] deq_pkt,
   input  logic                      deq_ready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointers carry one extra wrap bit so that full and empty are distinct:
   // equal pointers mean empty, equal index with differing wrap bit means full.
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   fetch_pkt_t       r_mem [DEPTH];

   logic [PTR_W-1:0] w_count;
   logic [PTR_W-1:0] w_deq_num;
   logic             w_enq_fire;
   logic             w_deq_fire;

   // Modulo subtraction of the extended pointers yields occupancy directly.
   assign w_count   = r_tail - r_head;
   assign count     = w_count;

   // Depends on registered pointers only: a full queue refuses a packet even
   // when a dequeue happens in the same cycle, keeping deq_ready off this path.
   assign enq_ready = (w_count != PTR_W'(DEPTH));

   assign w_enq_fire = enq_valid && enq_ready && !flush;
   assign w_deq_fire = deq_ready && deq_valid[0] && !flush;

   // Read slots: slot i shows the i-th oldest entry; the index arithmetic is
   // done in IDX_W bits so reads past the end of r_mem wrap to entry 0.
   for (genvar i = 0; i < ID_WIDTH; i++) begin : g_slot
      logic [IDX_W-1:0] w_rd_idx;

      assign deq_valid[i] = (w_count > PTR_W'(i));
      assign w_rd_idx     = r_head[IDX_W-1:0] + IDX_W'(i);
      assign deq_pkt[i]   = r_mem[w_rd_idx];
   end

   // Number of slots consumed on a dequeue. The valids are thermometer-coded,
   // so their popcount equals the index of the first invalid slot.
   // NOTE: combinational blocks use blocking assignments and give every output
   // a default before any conditional logic, so no latch can be inferred.
   always_comb begin
      w_deq_num = '0;
      for (int i = 0; i < ID_WIDTH; i++) begin
         w_deq_num = w_deq_num + PTR_W'(deq_valid[i]);
      end
   end

   // Pointer state. Flush wins over both ports and rewinds to entry 0.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_enq_fire) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_deq_fire) begin
            r_head <= r_head + w_deq_num;
         end
      end
   end

   // Packet storage.
   // NOTE: the storage array has no reset; entries outside head..tail are never
   // presented as valid, so their contents do not matter and stay plain RAM.
   always_ff @(posedge clk) begin
      if (w_enq_fire) begin
         r_mem[r_tail[IDX_W-1:0]] <= enq_pkt;
      end
   end

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//
// Directed bench for inst_queue (DEPTH=16, ID_WIDTH=2). The driver pushes the
// packet it expects to see on the dequeue side into a scoreboard whenever it
// offers a packet the queue must accept; a separate monitor pops and compares
// each valid slot whenever ID consumes. Directed checks cover occupancy,
// enq_ready, slot valids and the reset/flush/wrap boundaries.
// -----------------------------------------------------------------------------
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int DEPTH    = 16;
   localparam int ID_WIDTH = 2;

   logic                      clk;
   logic                      rst;
   logic                      flush;
   logic                      enq_valid;
   logic                      enq_ready;
   fetch_pkt_t                enq_pkt;
   logic [ID_WIDTH-1:0]       deq_valid;
   fetch_pkt_t [ID_WIDTH-1:0] deq_pkt;
   logic                      deq_ready;
   logic [$clog2(DEPTH):0]    count;

   int         n_vec  = 0;
   int         n_fail = 0;
   fetch_pkt_t sb [$];

   inst_queue #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_pkt   (enq_pkt),
      .deq_valid (deq_valid),
      .deq_pkt   (deq_pkt),
      .deq_ready (deq_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic fetch_pkt_t mk(input logic [31:0] pc);
      fetch_pkt_t p;
      p.pc          = pc;
      p.inst        = pc ^ 32'hA5A5_0000;
      p.pred_taken  = pc[2];
      p.pred_target = pc + 32'h0000_0100;
      return p;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one edge; inputs change and directed checks run 1 ns after it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic enq_one(input logic [31:0] pc, input bit exp_acc);
      enq_valid = 1'b1;
      enq_pkt   = mk(pc);
      check("enq_ready_before_enq", 128'(enq_ready), 128'(exp_acc));
      if (exp_acc) sb.push_back(mk(pc));
      cycle();
      enq_valid = 1'b0;
   endtask

   task automatic drain(input int n_cycles);
      deq_ready = 1'b1;
      repeat (n_cycles) cycle();
      deq_ready = 1'b0;
   endtask

   // Monitor: mid-cycle, when a dequeue will fire on the coming edge, every
   // valid slot must match the scoreboard in program order.
   always @(negedge clk) begin
      if (rst && deq_ready && !flush) begin
         for (int i = 0; i < ID_WIDTH; i++) begin
            if (deq_valid[i]) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 128'(deq_pkt[i]), 128'd0);
               end else begin
                  check($sformatf("deq_slot%0d", i), 128'(deq_pkt[i]), 128'(sb.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_pkt   = '0;
      deq_ready = 1'b0;
      #3;
      check("rst_count",     128'(count),     128'd0);
      check("rst_enq_ready", 128'(enq_ready), 128'd1);
      check("rst_deq_valid", 128'(deq_valid), 128'b00);
      #14 rst = 1'b1;
      cycle();

      // Reset mid-operation: five entries, then rst falls between edges.
      for (int k = 0; k < 5; k++) enq_one(32'h2000 + 32'(4 * k), 1'b1);
      check("fill5_count", 128'(count), 128'd5);
      #3;
      rst = 1'b0;
      sb.delete();
      #1;
      check("async_rst_count",     128'(count),     128'd0);
      check("async_rst_deq_valid", 128'(deq_valid), 128'b00);
      check("async_rst_enq_ready", 128'(enq_ready), 128'd1);
      cycle();
      #3 rst = 1'b1;
      cycle();
      enq_one(32'h3000, 1'b1);
      check("post_rst_count",     128'(count),         128'd1);
      check("post_rst_deq_valid", 128'(deq_valid),     128'b01);
      check("post_rst_slot0_pc",  128'(deq_pkt[0].pc), 128'h3000);
      drain(1);
      check("post_rst_drained", 128'(count), 128'd0);

      // Fill to full, refuse a 17th packet, drain in order.
      for (int k = 0; k < 16; k++) enq_one(32'h1000 + 32'(4 * k), 1'b1);
      check("full_count",     128'(count),     128'd16);
      check("full_enq_ready", 128'(enq_ready), 128'd0);
      enq_one(32'h1040, 1'b0);
      check("full_count_after_17th", 128'(count), 128'd16);
      drain(8);
      check("full_drained_count", 128'(count),     128'd0);
      check("full_drained_valid", 128'(deq_valid), 128'b00);

      // Dual dequeue with an odd number of entries.
      for (int k = 0; k < 3; k++) enq_one(32'h1000 + 32'(4 * k), 1'b1);
      check("odd_valid_first", 128'(deq_valid), 128'b11);
      deq_ready = 1'b1;
      cycle();
      check("odd_valid_second", 128'(deq_valid),     128'b01);
      check("odd_count_second", 128'(count),         128'd1);
      check("odd_slot0_pc",     128'(deq_pkt[0].pc), 128'h1008);
      cycle();
      deq_ready = 1'b0;
      check("odd_empty_count", 128'(count),     128'd0);
      check("odd_empty_valid", 128'(deq_valid), 128'b00);

      // Simultaneous enqueue and dequeue at count=1.
      enq_one(32'h4000, 1'b1);
      check("simul_count_before", 128'(count), 128'd1);
      enq_valid = 1'b1;
      enq_pkt   = mk(32'h4004);
      deq_ready = 1'b1;
      sb.push_back(mk(32'h4004));
      cycle();
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      check("simul_count_after", 128'(count),         128'd1);
      check("simul_valid_after", 128'(deq_valid),     128'b01);
      check("simul_slot0_pc",    128'(deq_pkt[0].pc), 128'h4004);
      drain(1);

      // Wrap: rewind pointers with a flush, 14 in / 14 out, then 4 more.
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      for (int k = 0; k < 14; k++) enq_one(32'h5000 + 32'(4 * k), 1'b1);
      drain(7);
      check("wrap_empty_count", 128'(count), 128'd0);
      for (int k = 0; k < 4; k++) enq_one(32'h6000 + 32'(4 * k), 1'b1);
      check("wrap_count",    128'(count),         128'd4);
      check("wrap_valid",    128'(deq_valid),     128'b11);
      check("wrap_slot0_pc", 128'(deq_pkt[0].pc), 128'h6000);
      check("wrap_slot1_pc", 128'(deq_pkt[1].pc), 128'h6004);
      drain(1);
      check("wrap_slot0_pc_b", 128'(deq_pkt[0].pc), 128'h6008);
      check("wrap_slot1_pc_b", 128'(deq_pkt[1].pc), 128'h600C);
      drain(1);
      check("wrap_drained", 128'(count), 128'd0);

      // Flush at count=7 with an enqueue and a dequeue offered.
      for (int k = 0; k < 7; k++) enq_one(32'h7000 + 32'(4 * k), 1'b1);
      check("pre_flush_count", 128'(count), 128'd7);
      flush     = 1'b1;
      enq_valid = 1'b1;
      enq_pkt   = mk(32'h7FFC);
      deq_ready = 1'b1;
      sb.delete();
      cycle();
      flush     = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      check("flush_count",     128'(count),     128'd0);
      check("flush_deq_valid", 128'(deq_valid), 128'b00);
      check("flush_enq_ready", 128'(enq_ready), 128'd1);
      enq_one(32'h8000, 1'b1);
      check("post_flush_count",    128'(count),         128'd1);
      check("post_flush_slot0_pc", 128'(deq_pkt[0].pc), 128'h8000);
      drain(1);

      cycle();
      check("sb_drained", 128'(sb.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_inst_queue

// File: doc/inst_queue.md
# inst_queue

Decoupling buffer between the fetch stage and the backend's ID stage. Fetch writes at most one fetch packet (PC, instruction word, branch prediction) per cycle. The ID stage reads up to ID_WIDTH oldest packets per cycle, in program order. A backend flush empties the queue in one cycle so the redirected fetch stream can refill it.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2·ID_WIDTH
- ID_WIDTH, 2, dequeue slots per cycle; must match the ID stage decode width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  backend_flush; discards all entries
- enq_valid  in  1  fetch presents a packet
- enq_ready  out  1  queue can accept a packet this cycle
- enq_pkt  in  fetch_pkt_t  {pc[31:0], inst[31:0], pred_taken, pred_target[31:0]}
- deq_valid  out  ID_WIDTH  slot i holds the i-th oldest entry; contiguous from slot 0
- deq_pkt  out  fetch_pkt_t[ID_WIDTH]  packet per slot; undefined when deq_valid[i]=0
- deq_ready  in  1  ID stage consumes every slot with deq_valid[i]=1 this cycle
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer with head and tail pointers. Each pointer is $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Empty when head==tail. Full when the index bits are equal and the wrap bits differ. count = tail − head, modulo 2^($clog2(DEPTH)+1).
- Enqueue fires when enq_valid && enq_ready && !flush: write to mem[tail], tail+1.
- enq_ready = (count != DEPTH). It depends only on registered state, with no combinational path from deq_ready. A full queue therefore refuses a packet even if a dequeue happens in the same cycle.
- Slot i: deq_valid[i] = (count > i); deq_pkt[i] = mem[head+i], with the index wrapping modulo DEPTH.
- Dequeue fires when deq_ready && deq_valid[0] && !flush: head += popcount(deq_valid). The valid bits are thermometer-coded, so popcount is the index of the first 0.
- Partial consumption is not supported. deq_ready means "take all presented slots".
- Simultaneous enqueue and dequeue are allowed; count changes by +1 − n.
- Flush has priority over both ports: head ← 0, tail ← 0, and any enqueue or dequeue in that cycle is dropped.
- Reset clears the pointers only. mem is not reset.

## Timing
- Reset values: enq_ready=1, deq_valid=0, count=0. These apply as soon as rst falls, independent of clk.
- Enqueue-to-dequeue latency is 1 cycle: a packet written at edge N is visible in deq_pkt[0] after edge N.
- Flush takes effect at the next edge. The cycle after flush shows deq_valid=0, count=0, enq_ready=1.
- A packet offered in the flush cycle is lost. Fetch must re-present from the redirect PC.
- Wrap-around: tail going from DEPTH−1 to 0 toggles the wrap bit. Slot reads across the end of mem wrap to index 0.
- Only head, tail and mem are sequential. The deq_* outputs are combinational from this registered state.

## Structure
- fetch_pkt_t goes in the shared uop_types package. IQ_DEPTH goes in cpu_params; ID_WIDTH already lives there.
- No sub-module. Pointer arithmetic and the read mux are local generate loops.

## Test plan
- Reset mid-operation: fill 5 entries, drive rst=0 between edges -> count=0, deq_valid=00 and enq_ready=1 immediately; after release, the first enqueue appears in slot 0.
- Fill to full: 16 enqueues with deq_ready=0 -> count=16, enq_ready=0; a 17th enq_valid is not accepted; entries 0..15 come out in order, PCs 0x1000..0x103C.
- Dual dequeue and odd tail: enqueue 3, then hold deq_ready=1 -> cycle 1 takes PCs 0x1000 and 0x1004 (deq_valid=11); cycle 2 takes 0x1008 (deq_valid=01); then empty.
- Simultaneous enqueue and dequeue at count=1 -> next count=1, with the new packet in slot 0.
- Wrap: 14 enqueues, 14 dequeues, then 4 enqueues -> tail index wraps to 2; slots read mem[14] and mem[15], then mem[0] and mem[1], in order.
- Flush with enq_valid=1 and deq_ready=1 at count=7 -> next cycle count=0, deq_valid=00, and neither the offered packet nor any dequeue took effect.
